seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Downstream display stage for the HH:MM:SS clock: it takes binary hours, minutes and seconds and drives a six-digit multiplexed seven-segment display. It splits each field into tens and units and scans one digit at a time at a programmable rate. It drives the `number` segment bus and the `digit_block` digit-select bus. Time inputs are snapshotted once per frame, so a display frame never mixes two different times.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥2, prescaler width `$clog2(SCAN_DIV)`.
- `clk` in, 1: system clock.
- `rst` in, 1: reset, asynchronous, active-low. One clock domain only.
- `hours` in, 6: binary hours; legal range 0–23.
- `minutes` in, 6: binary minutes; legal range 0–59.
- `seconds` in, 6: binary seconds; legal range 0–59.
- `sec_tick` in, 1: one-cycle pulse per elapsed second; used only by the DP blink feature.
- `number` out, 8: segment pattern, active-low; bits 6:0 are the digit pattern, bit 7 is the decimal point.
- `digit_block` out, 6: digit select, active-low one-cold; bit 0 = seconds units, bit 5 = hours tens.

## Operation
- **Prescaler** `div_cnt`:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `scan_en` pulses for one cycle when `div_cnt == SCAN_DIV-1`.
- **Digit index** `idx`:
  - Range 0..5; advances on `scan_en`; wraps 5→0.
  - Digit order: 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hr units, 5 hr tens.
- **Snapshot:** on the `scan_en` that moves `idx` from 5→0, `hours`, `minutes` and `seconds` are registered into shadow registers. The first snapshot is taken on the first `scan_en` after reset.
- **Split:** `tens = v/10`, `units = v%10` on shadow values, implemented by compare/subtract (no divider). The result is a pure function of the shadow value.
- **Range check:** if seconds or minutes > 59, or hours > 23, both digits of that field show DASH (segment g only, `8'hBF`). Other fields are unaffected.
- **Pattern select:** digit value 0–9 maps to the shared NUMBER_0..NUMBER_9 constants. The DP bit is off (1) unless the blink feature lights it.
- **Anti-ghost:**
  - In the cycle where `scan_en` is high, `digit_block` is forced to `6'b111111`.
  - In the next cycle, `digit_block` selects the new `idx` and `number` carries that digit's pattern.
- **Reset (async assert, sync release):**
  - Outputs: `number = 8'hFF`, `digit_block = 6'b111111`.
  - Internal: `idx = 0`, `div_cnt = 0`, shadows = 0, blink flag = 0.
- **Reset mid-scan:** all outputs go blank immediately; the scan restarts from `idx` 0 with no partial frame.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- After reset release:
  - `scan_en` first fires in cycle SCAN_DIV (cycles counted from 1).
  - The first digit, seconds units of the first snapshot, is selected in cycle SCAN_DIV+1.
- Each digit is dark for 1 cycle and lit for SCAN_DIV-1 cycles; a frame is 6×SCAN_DIV cycles.
- Input-to-display latency:
  - Minimum is 1 cycle from the snapshot edge.
  - Maximum is 6×SCAN_DIV+1 cycles.
  - Input changes between snapshots are invisible.
- `sec_tick` coincident with the snapshot edge: the blink flag toggles and the snapshot is taken in the same cycle; both take effect on the next lit digit.

## Configuration
- Macro: `SEG7_DP_BLINK_EN`.
- Defined:
  - Each `sec_tick` toggles a blink flag.
  - While the flag is 1, the DP bit (`number[7] = 0`) is lit on idx 2 and idx 4, acting as the HH.MM.SS separators.
  - DASH digits follow the same DP rule.
- Undefined:
  - The blink flag is not built and `sec_tick` is ignored; the port is still present.
  - `number[7]` is constant 1.

## Structure
- Package `seg7_pkg`:
  - NUMBER_0..NUMBER_9 patterns, SEG_DASH (`8'hBF`), SEG_BLANK (`8'hFF`).
  - `digit_idx_t` (3-bit), DIGIT_COUNT = 6.
  - Field limits: HOURS_MAX = 23, MINSEC_MAX = 59.
- Sub-module `bcd_split`:
  - Input: 6-bit binary.
  - Outputs: 4-bit tens, 4-bit units, `out_of_range` flag against a max parameter.
  - Combinational; instantiated three times.

## Test plan
All scenarios run with SCAN_DIV = 4.
- **Reset:** hold `rst` low, then release → outputs `8'hFF` / `6'b111111`. Cycle 4: `digit_block = 111111`. Cycle 5: `digit_block = 111110` with the seconds-units pattern.
- **Full frame:** inputs 12:34:56 → over one frame, `number` shows 6,5,4,3,2,1 with `digit_block` 111110, 111101, 111011, 110111, 101111, 011111. Each digit is lit for 3 cycles, and an all-ones cycle separates them.
- **Mid-frame change:** change `seconds` from 56 to 57 while idx = 2 → the current frame still shows 6; the next frame shows 7.
- **Out of range:** `minutes = 60`, `hours = 24` → idx 2–5 show `8'hBF`; seconds digits stay normal.
- **Blink (macro defined):** pulse `sec_tick` once → DP is lit on idx 2 and 4 in the next frame; a second pulse turns it off. With the macro undefined, `number[7]` stays 1 throughout.
- **Reset mid-digit:** assert `rst` while idx = 3 → outputs go blank in the same cycle; after release, scanning restarts at idx 0 exactly as in the reset scenario.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and pattern helper for the seven-segment scanner
// Segment encoding is active-low: bits 6:0 = segments a..g, bit 7 = decimal point.
package seg7_pkg;

    localparam logic [7:0] NUMBER_0  = 8'hC0;
    localparam logic [7:0] NUMBER_1  = 8'hF9;
    localparam logic [7:0] NUMBER_2  = 8'hA4;
    localparam logic [7:0] NUMBER_3  = 8'hB0;
    localparam logic [7:0] NUMBER_4  = 8'h99;
    localparam logic [7:0] NUMBER_5  = 8'h92;
    localparam logic [7:0] NUMBER_6  = 8'h82;
    localparam logic [7:0] NUMBER_7  = 8'hF8;
    localparam logic [7:0] NUMBER_8  = 8'h80;
    localparam logic [7:0] NUMBER_9  = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int DIGIT_COUNT = 6;
    typedef logic [2:0] digit_idx_t;

    localparam logic [5:0] HOURS_MAX  = 6'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       out_of_range;
    } split_t;

    // Digit value to segment pattern, decimal point off.
    function automatic logic [7:0] seg_pattern(input logic [3:0] value);
        logic [7:0] pat;
        case (value)
            4'd0:    pat = NUMBER_0;
            4'd1:    pat = NUMBER_1;
            4'd2:    pat = NUMBER_2;
            4'd3:    pat = NUMBER_3;
            4'd4:    pat = NUMBER_4;
            4'd5:    pat = NUMBER_5;
            4'd6:    pat = NUMBER_6;
            4'd7:    pat = NUMBER_7;
            4'd8:    pat = NUMBER_8;
            4'd9:    pat = NUMBER_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_bcd_split.sv
// rtl/seg7_bcd_split.sv - combinational binary-to-tens/units split with range flag
// Ports:
//   value        in  6  binary field value
//   tens         out 4  value / 10
//   units        out 4  value % 10
//   out_of_range out 1  value > MAX_VALUE
module bcd_split
    import seg7_pkg::*;
#(
    parameter logic [5:0] MAX_VALUE = MINSEC_MAX
) (
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       out_of_range
);

    logic [5:0] rem;

    // Repeated compare/subtract; six steps cover the full 6-bit range (63 -> 6 tens).
    always_comb begin
        rem  = value;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        units        = rem[3:0];
        out_of_range = (value > MAX_VALUE);
    end

endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - six-digit multiplexed seven-segment scanner for HH:MM:SS
// Optional feature macro: SEG7_DP_BLINK_EN (sec_tick toggles DP separators on idx 2 and 4).
// Ports:
//   clk          in  1  system clock
//   rst          in  1  asynchronous active-low reset
//   hours        in  6  binary hours (0-23 legal)
//   minutes      in  6  binary minutes (0-59 legal)
//   seconds      in  6  binary seconds (0-59 legal)
//   sec_tick     in  1  one-cycle pulse per second (DP blink only)
//   number       out 8  active-low segment pattern, bit 7 = DP
//   digit_block  out 6  active-low one-cold digit select, bit 0 = seconds units
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       sec_tick,
    output logic [7:0] number,
    output logic [5:0] digit_block
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(SCAN_DIV - 2);
    localparam digit_idx_t       IDX_LAST = digit_idx_t'(DIGIT_COUNT - 1);

    logic [DIV_W-1:0] div_cnt;
    digit_idx_t       idx;       // digit that the next scan_en will light
    logic [5:0]       hours_q, minutes_q, seconds_q;
    logic [5:0]       hours_nxt, minutes_nxt, seconds_nxt;
    logic             scan_en, pre_blank, snap;
    logic             dp_on;
    split_t           sec_s, min_s, hr_s;
    logic [3:0]       digit_val;
    logic             digit_oor;
    logic [7:0]       pattern;

    assign scan_en   = (div_cnt == DIV_LAST);
    assign pre_blank = (div_cnt == DIV_PRE);
    // Entering idx 0 starts a new frame: that is the only point the inputs are sampled.
    assign snap      = scan_en && (idx == digit_idx_t'(0));

    // Split the shadow's next value so a fresh snapshot is shown on the very digit it opens.
    assign hours_nxt   = snap ? hours   : hours_q;
    assign minutes_nxt = snap ? minutes : minutes_q;
    assign seconds_nxt = snap ? seconds : seconds_q;

    bcd_split #(.MAX_VALUE(MINSEC_MAX)) u_split_sec (
        .value(seconds_nxt), .tens(sec_s.tens), .units(sec_s.units), .out_of_range(sec_s.out_of_range)
    );
    bcd_split #(.MAX_VALUE(MINSEC_MAX)) u_split_min (
        .value(minutes_nxt), .tens(min_s.tens), .units(min_s.units), .out_of_range(min_s.out_of_range)
    );
    bcd_split #(.MAX_VALUE(HOURS_MAX)) u_split_hr (
        .value(hours_nxt), .tens(hr_s.tens), .units(hr_s.units), .out_of_range(hr_s.out_of_range)
    );

`ifdef SEG7_DP_BLINK_EN
    logic blink, blink_nxt;
    assign blink_nxt = blink ^ sec_tick;
    // A tick on the lighting edge already affects the digit being lit.
    assign dp_on     = blink_nxt && ((idx == digit_idx_t'(2)) || (idx == digit_idx_t'(4)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink <= 1'b0;
        end else begin
            blink <= blink_nxt;
        end
    end
`else
    logic unused_sec_tick;
    assign unused_sec_tick = sec_tick;
    assign dp_on           = 1'b0;
`endif

    always_comb begin
        digit_val = 4'd0;
        digit_oor = 1'b0;
        case (idx)
            3'd0:    begin digit_val = sec_s.units; digit_oor = sec_s.out_of_range; end
            3'd1:    begin digit_val = sec_s.tens;  digit_oor = sec_s.out_of_range; end
            3'd2:    begin digit_val = min_s.units; digit_oor = min_s.out_of_range; end
            3'd3:    begin digit_val = min_s.tens;  digit_oor = min_s.out_of_range; end
            3'd4:    begin digit_val = hr_s.units;  digit_oor = hr_s.out_of_range;  end
            3'd5:    begin digit_val = hr_s.tens;   digit_oor = hr_s.out_of_range;  end
            default: begin digit_val = 4'd0;        digit_oor = 1'b0;               end
        endcase
        pattern = digit_oor ? SEG_DASH : seg_pattern(digit_val);
        if (dp_on) begin
            pattern[7] = 1'b0;
        end
    end

    // Outputs go dark one cycle before each scan_en so the select bus is all-ones
    // exactly during the scan_en cycle, then light the new digit on the scan_en edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            number      <= SEG_BLANK;
            digit_block <= 6'b111111;
        end else begin
            div_cnt   <= scan_en ? '0 : div_cnt + DIV_W'(1);
            hours_q   <= hours_nxt;
            minutes_q <= minutes_nxt;
            seconds_q <= seconds_nxt;
            if (scan_en) begin
                idx         <= (idx == IDX_LAST) ? '0 : idx + digit_idx_t'(1);
                number      <= pattern;
                digit_block <= ~(6'b000001 << idx);
            end else if (pre_blank) begin
                number      <= SEG_BLANK;
                digit_block <= 6'b111111;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - self-checking bench for seg7_scanner
module tb_seg7_scanner;

    localparam int SD   = 4;
    localparam int MAXC = 1024;
    localparam int NV   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hours, minutes, seconds;
    logic       sec_tick;
    logic [7:0] number;
    logic [5:0] digit_block;

    seg7_scanner #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_tick(sec_tick), .number(number), .digit_block(digit_block)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic [47:0] exp;   // byte d = expected pattern of digit d
    } vec_t;

    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [5:0] in_h [0:MAXC-1];
    logic [5:0] in_m [0:MAXC-1];
    logic [5:0] in_s [0:MAXC-1];
    logic       tk   [0:MAXC-1];
    logic [7:0] obs_num [0:MAXC-1];
    logic [5:0] obs_db  [0:MAXC-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_ref(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected outputs in cycle c after reset release, from the frame/slot timing rules.
    function automatic void model_out(input int c, output logic [7:0] en, output logic [5:0] ed);
        int k, slot, pos, dig, frame, sc, v, mx;
        logic [7:0] p;
        en = 8'hFF;
        ed = 6'h3F;
        if (c <= SD) return;
        k    = c - SD - 1;
        slot = k / SD;
        pos  = k % SD;
        if (pos == SD - 1) return;
        dig   = slot % 6;
        frame = slot / 6;
        sc    = SD * (6 * frame + 1);
        case (dig / 2)
            0:       begin v = int'(in_s[sc]); mx = 59; end
            1:       begin v = int'(in_m[sc]); mx = 59; end
            default: begin v = int'(in_h[sc]); mx = 23; end
        endcase
        if (v > mx) p = 8'hBF;
        else        p = seg_ref((dig % 2 == 0) ? v % 10 : v / 10);
`ifdef SEG7_DP_BLINK_EN
        begin
            int par = 0;
            for (int i = 1; i <= SD * (slot + 1); i++) par ^= int'(tk[i]);
            if (par == 1 && (dig == 2 || dig == 4)) p[7] = 1'b0;
        end
`endif
        en = p;
        ed = ~(6'b000001 << dig);
    endfunction

    task automatic run_cycle();
        logic [7:0] en;
        logic [5:0] ed;
        n++;
        in_h[n] = hours;
        in_m[n] = minutes;
        in_s[n] = seconds;
        tk[n]   = sec_tick;
        @(negedge clk);
        obs_num[n] = number;
        obs_db[n]  = digit_block;
        model_out(n, en, ed);
        check($sformatf("model_num c%0d", n), number, en);
        check($sformatf("model_sel c%0d", n), digit_block, ed);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_num", number, 8'hFF);
        check("reset_sel", digit_block, 6'h3F);
        rst = 1'b1;
        n   = 0;
        for (int i = 0; i < MAXC; i++) begin
            in_h[i] = '0; in_m[i] = '0; in_s[i] = '0; tk[i] = 1'b0;
            obs_num[i] = '0; obs_db[i] = '0;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 6'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    initial begin
        logic [5:0] sel;
        rst = 1'b0;
        sec_tick = 1'b0;
        set_time(0, 0, 0);

        vecs[0] = '{6'd12, 6'd34, 6'd56, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
        vecs[1] = '{6'd0,  6'd0,  6'd0,  {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[2] = '{6'd23, 6'd59, 6'd59, {8'hA4, 8'hB0, 8'h92, 8'h90, 8'h92, 8'h90}};
        vecs[3] = '{6'd24, 6'd60, 6'd5,  {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hC0, 8'h92}};
        vecs[4] = '{6'd9,  6'd10, 6'd7,  {8'hC0, 8'h90, 8'hF9, 8'hC0, 8'hC0, 8'hF8}};
        vecs[5] = '{6'd63, 6'd59, 6'd60, {8'hBF, 8'hBF, 8'h92, 8'h90, 8'hBF, 8'hBF}};
        vecs[6] = '{6'd23, 6'd0,  6'd48, {8'hA4, 8'hB0, 8'hC0, 8'hC0, 8'h99, 8'h80}};

        // Table: one full frame per vector, first frame after reset.
        for (int t = 0; t < NV; t++) begin
            do_reset();
            set_time(int'(vecs[t].h), int'(vecs[t].m), int'(vecs[t].s));
            repeat (30) run_cycle();
            check($sformatf("vec%0d start_dark", t), obs_db[SD], 6'h3F);
            for (int d = 0; d < 6; d++) begin
                sel = ~(6'b000001 << d);
                check($sformatf("vec%0d d%0d first", t, d), obs_num[5 + 4 * d], vecs[t].exp[8 * d +: 8]);
                check($sformatf("vec%0d d%0d last", t, d), obs_num[7 + 4 * d], vecs[t].exp[8 * d +: 8]);
                check($sformatf("vec%0d d%0d sel", t, d), obs_db[5 + 4 * d], sel);
                check($sformatf("vec%0d d%0d dark", t, d), obs_db[8 + 4 * d], 6'h3F);
            end
        end

        // Mid-frame change during idx 2: invisible until the next frame.
        do_reset();
        set_time(12, 34, 56);
        repeat (12) run_cycle();
        set_time(12, 47, 57);
        repeat (34) run_cycle();
        check("midchg sec_units_f0", obs_num[5], 8'h82);
        check("midchg min_units_f0", obs_num[13], 8'h99);
        check("midchg min_tens_f0", obs_num[17], 8'hB0);
        check("midchg sec_units_f1", obs_num[29], 8'hF8);
        check("midchg min_units_f1", obs_num[37], 8'hF8);
        check("midchg min_tens_f1", obs_num[41], 8'h99);

        // Blink: ticks coincide with the frame-1 and frame-2 snapshot edges.
        do_reset();
        set_time(12, 34, 56);
        repeat (27) run_cycle();
        sec_tick = 1'b1; run_cycle(); sec_tick = 1'b0;
        repeat (23) run_cycle();
        sec_tick = 1'b1; run_cycle(); sec_tick = 1'b0;
        repeat (12) run_cycle();
`ifdef SEG7_DP_BLINK_EN
        check("blink f0 idx2 off", obs_num[13], 8'h99);
        check("blink f1 idx0", obs_num[29], 8'h82);
        check("blink f1 idx2 on", obs_num[37], 8'h19);
        check("blink f1 idx3", obs_num[41], 8'hB0);
        check("blink f1 idx4 on", obs_num[45], 8'h24);
        check("blink f2 idx2 off", obs_num[61], 8'h99);
`else
        for (int c = 1; c <= 64; c++) begin
            check($sformatf("dp_off c%0d", c), {7'd0, obs_num[c][7]}, 8'd1);
        end
`endif

        // Reset asserted while idx 3 is lit.
        do_reset();
        set_time(12, 34, 56);
        repeat (16) run_cycle();
        n++;
        @(negedge clk);
        check("midrst pre_sel", digit_block, 6'b110111);
        rst = 1'b0;
        #1;
        check("midrst num", number, 8'hFF);
        check("midrst sel", digit_block, 6'h3F);
        do_reset();
        repeat (8) run_cycle();
        check("midrst c1 sel", obs_db[1], 6'h3F);
        check("midrst c4 sel", obs_db[4], 6'h3F);
        check("midrst c5 sel", obs_db[5], 6'b111110);
        check("midrst c5 num", obs_num[5], 8'h82);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) begin
                set_time(int'($urandom_range(27)), int'($urandom_range(63)), int'($urandom_range(63)));
            end
            sec_tick = ($urandom_range(9) == 0);
            run_cycle();
        end
        sec_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
